dma_bus_arbiter: RTL and testbench
==================================

DMA_BUS_ARBITER -- requirements
Module: dma_bus_arbiter

Interface
REQ-001 Parameter BURST_MAX, default 8, max long-word cycles per tenure; legal range 1..15.
REQ-002 Parameter HOLDOFF, default 2, idle clocks after release before re-request; legal range 0..7.
REQ-003 SCLK  in  1  system clock (CPUCLKB); all state changes on rising edge.
REQ-004 _RST  in  1  reset, asynchronous, active-low.
REQ-005 DMA_REQ  in  1  active-high; the FIFO/datapath has data to move.
REQ-006 CYCLE_END  in  1  one-clock pulse; the datapath finished one long-word bus cycle (_STERM or _DSACK seen).
REQ-007 CYCLE_BUSY  in  1  high while the datapath has a bus cycle in progress (_AS asserted by us).
REQ-008 DMA_DONE  in  1  one-clock pulse; the transfer count has expired.
REQ-009 _BG  in  1  bus grant from the CPU, async to SCLK.
REQ-010 _AS_IN  in  1  bus _AS as seen on the pins, async.
REQ-011 _BGACK_IN  in  1  bus _BGACK as seen on the pins, async.
REQ-012 _BERR  in  1  bus error, async.
REQ-013 ERR_CLR  in  1  one-clock pulse; clears BUS_ERR.
REQ-014 _BR  out  1  bus request, active-low.
REQ-015 _BGACK_OUT  out  1  bus grant acknowledge value.
REQ-016 BGACK_OE  out  1  high = drive _BGACK_OUT onto the pin; low = tristate.
REQ-017 OWN  out  1  high while this block is bus master.
REQ-018 DMA_GO  out  1  high = the datapath may start a new bus cycle.
REQ-019 BUS_ERR  out  1  sticky flag; a _BERR occurred during a tenure.

Function
REQ-020 _BG, _AS_IN, _BGACK_IN and _BERR shall each pass through a 2-flop synchronizer; all decisions use the synchronized values (s_BG, s_AS, s_BGACK, s_BERR).
REQ-021 States shall be IDLE, REQ, OWNED, DRAIN, RELEASE, HOLD; the encoding is free.
REQ-022 IDLE: when DMA_REQ=1 and BUS_ERR=0, go to REQ next clock; _BR=0 from that edge.
REQ-023 REQ: go to OWNED when s_BG=0 and s_AS=1 and s_BGACK=1 all hold in the same clock.
REQ-024 REQ: if DMA_REQ drops before the OWNED condition is met, negate _BR and return to IDLE; a withdrawn _BG keeps the block in REQ.
REQ-025 Entry to OWNED: _BGACK_OUT=0, BGACK_OE=1 and OWN=1 on the same edge; _BR=1 on that edge.
REQ-026 OWNED: DMA_GO = DMA_REQ and not (burst limit reached).
REQ-027 OWNED: a 4-bit burst counter clears on entry and increments on each CYCLE_END; it saturates at BURST_MAX.
REQ-028 OWNED exits to DRAIN when any of these hold: DMA_REQ=0, counter=BURST_MAX, DMA_DONE=1.
REQ-029 DRAIN: DMA_GO=0; stay until CYCLE_BUSY=0, then go to RELEASE. DRAIN is passed through in zero extra clocks if CYCLE_BUSY is already 0.
REQ-030 RELEASE lasts exactly 1 clock: OWN=0, _BGACK_OUT=1 driven (BGACK_OE=1). On the next edge BGACK_OE=0 and the block enters HOLD.
REQ-031 HOLD: count HOLDOFF clocks, then go to IDLE; with HOLDOFF=0, go directly to IDLE.
REQ-032 s_BERR=0 in OWNED or DRAIN: set BUS_ERR and go to RELEASE immediately, ignoring CYCLE_BUSY; DMA_GO=0 on the same edge.
REQ-033 BUS_ERR blocks new requests until ERR_CLR. ERR_CLR and a new _BERR in the same clock: set wins.
REQ-034 DMA_DONE and CYCLE_END in the same clock: count the cycle, then exit per REQ-028.
REQ-035 DMA_GO and OWN shall never be high outside OWNED (OWN is also high in DRAIN).
REQ-036 _BR=0 and BGACK_OE=1 shall never both be true except on the edge entering OWNED.

Reset
REQ-037 While _RST=0: state=IDLE, _BR=1, _BGACK_OUT=1, BGACK_OE=0, OWN=0, DMA_GO=0, BUS_ERR=0, counters=0, synchronizers=1.
REQ-038 Reset asserted mid-tenure shall release the bus immediately (asynchronous), with no RELEASE cycle.

Verification
REQ-039 DMA_REQ=1 from reset, _BG tied to follow _BR after 1 clock, bus idle -> _BR low at clock 1, OWN high at clock 5 (1 clock of grant latency + 2 synchronizer stages + 1 clock decision), DMA_GO high the same clock.
REQ-040 BURST_MAX=8 with DMA_REQ held high and CYCLE_END every 6 clocks -> exactly 8 pulses counted; DMA_GO low after the 8th; release; HOLD for 2 clocks; _BR re-asserted.
REQ-041 _AS_IN held low for 10 clocks after _BG -> OWN stays 0 until 3 clocks after _AS_IN goes high.
REQ-042 _BERR pulsed while CYCLE_BUSY=1 -> next-but-two clock: OWN=0, BUS_ERR=1; no new _BR until ERR_CLR, then a normal request.
REQ-043 DMA_REQ dropped in REQ before the grant -> _BR=1 next clock; state IDLE; BGACK_OE never rises.
REQ-044 _RST pulsed low while in OWNED -> OWN, DMA_GO and BGACK_OE are 0 within the same time step; after reset, normal acquisition.

Source files
------------

// File: rtl/dma_bus_arbiter_if.sv
// Handshake bundle between the DMA bus arbiter, its datapath and the 68k-style bus pins.
// The master modport is the arbiter's view; the slave modport is the datapath/bus side.
interface dma_bus_arbiter_if;
  logic dma_req;
  logic cycle_end;
  logic cycle_busy;
  logic dma_done;
  logic bg_n;
  logic bus_as_n;
  logic bus_bgack_n;
  logic berr_n;
  logic err_clr;
  logic br_n;
  logic bgack_n;
  logic bgack_oe;
  logic own;
  logic dma_go;
  logic bus_err;

  modport master (
    input  dma_req, cycle_end, cycle_busy, dma_done,
    input  bg_n, bus_as_n, bus_bgack_n, berr_n, err_clr,
    output br_n, bgack_n, bgack_oe, own, dma_go, bus_err
  );

  modport slave (
    output dma_req, cycle_end, cycle_busy, dma_done,
    output bg_n, bus_as_n, bus_bgack_n, berr_n, err_clr,
    input  br_n, bgack_n, bgack_oe, own, dma_go, bus_err
  );
endinterface

// File: rtl/dma_bus_arbiter.sv
// Bus-request/grant arbiter that acquires the CPU bus for DMA bursts of up to
// BURST_MAX long-word cycles, releases it cleanly and enforces a hold-off gap.
module dma_bus_arbiter #(
  parameter int BURST_MAX = 8,
  parameter int HOLDOFF   = 2
) (
  input logic             clk,
  input logic             rst_n,
  dma_bus_arbiter_if.master bus
);
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    OWNED,
    DRAIN,
    RELEASE,
    HOLD
  } state_t;

  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);
  localparam logic [2:0] HOLD_LIM  = 3'(HOLDOFF - 1);

  state_t     state_reg, state_next;
  logic [3:0] burst_reg, burst_next;
  logic [2:0] hold_reg, hold_next;
  logic       bus_err_reg, bus_err_next;
  logic [3:0] sync1_reg, sync2_reg;
  logic [3:0] async_pins;
  logic       s_bg, s_as, s_bgack, s_berr;
  logic       limit;

  assign async_pins = {bus.bg_n, bus.bus_as_n, bus.bus_bgack_n, bus.berr_n};

  // Two-stage synchronizers; idle (negated) level is 1 for all pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 4'hF;
      sync2_reg <= 4'hF;
    end else begin
      sync1_reg <= async_pins;
      sync2_reg <= sync1_reg;
    end
  end

  assign s_bg    = sync2_reg[3];
  assign s_as    = sync2_reg[2];
  assign s_bgack = sync2_reg[1];
  assign s_berr  = sync2_reg[0];
  assign limit   = (burst_reg == BURST_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      burst_reg   <= 4'd0;
      hold_reg    <= 3'd0;
      bus_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      burst_reg   <= burst_next;
      hold_reg    <= hold_next;
      bus_err_reg <= bus_err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    burst_next   = burst_reg;
    hold_next    = hold_reg;
    bus_err_next = bus_err_reg;
    // Clear first so a same-clock bus error below overrides it.
    if (bus.err_clr) begin
      bus_err_next = 1'b0;
    end
    case (state_reg)
      IDLE: begin
        if (bus.dma_req && !bus_err_reg) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (!bus.dma_req) begin
          state_next = IDLE;
        end else if (!s_bg && s_as && s_bgack) begin
          state_next = OWNED;
          burst_next = 4'd0;
        end
      end
      OWNED: begin
        if (bus.cycle_end && !limit) begin
          burst_next = burst_reg + 4'd1;
        end
        if (!s_berr) begin
          bus_err_next = 1'b1;
          state_next   = RELEASE;
        end else if (!bus.dma_req || limit || bus.dma_done) begin
          // Skip DRAIN entirely when no bus cycle is outstanding.
          state_next = bus.cycle_busy ? DRAIN : RELEASE;
        end
      end
      DRAIN: begin
        if (!s_berr) begin
          bus_err_next = 1'b1;
          state_next   = RELEASE;
        end else if (!bus.cycle_busy) begin
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        hold_next  = 3'd0;
        state_next = (HOLDOFF == 0) ? IDLE : HOLD;
      end
      HOLD: begin
        if (hold_reg == HOLD_LIM) begin
          state_next = IDLE;
        end else begin
          hold_next = hold_reg + 3'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode the registered state, so reset releases the bus at once.
  assign bus.br_n     = (state_reg != REQ);
  assign bus.own      = (state_reg == OWNED) || (state_reg == DRAIN);
  assign bus.bgack_n  = !bus.own;
  assign bus.bgack_oe = bus.own || (state_reg == RELEASE);
  assign bus.dma_go   = (state_reg == OWNED) && bus.dma_req && !limit;
  assign bus.bus_err  = bus_err_reg;
endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Scenario bench for dma_bus_arbiter: acquisition latency, burst limit, done/drain,
// bus-busy hold-off, bus error, request withdrawal and asynchronous reset.
module tb_dma_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic bg_auto, bg_man, bg_q;
  int   total = 0;
  int   bad = 0;
  int   exp_q[$];

  dma_bus_arbiter_if bif();

  dma_bus_arbiter #(.BURST_MAX(8), .HOLDOFF(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
  );

  always #5 clk = ~clk;

  // CPU model: grant follows bus request one clock later when enabled.
  always @(posedge clk) bg_q <= bif.br_n;
  assign bif.bg_n = bg_auto ? bg_q : bg_man;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      total++;
      if (!bif.br_n && bif.bgack_oe) begin
        bad++;
        $display("FAIL br_oe_overlap: br_n=%b bgack_oe=%b required not both active", bif.br_n, bif.bgack_oe);
      end
      total++;
      if (bif.dma_go && !bif.own) begin
        bad++;
        $display("FAIL go_without_own: dma_go=%b own=%b", bif.dma_go, bif.own);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input bit req, input bit auto_bg);
    rst_n = 1'b0;
    bif.dma_req = 1'b0; bif.cycle_end = 1'b0; bif.cycle_busy = 1'b0; bif.dma_done = 1'b0;
    bif.bus_as_n = 1'b1; bif.bus_bgack_n = 1'b1; bif.berr_n = 1'b1; bif.err_clr = 1'b0;
    bg_man = 1'b1; bg_auto = auto_bg;
    repeat (3) @(negedge clk);
    bif.dma_req = req;
    rst_n = 1'b1;
  endtask

  task automatic wait_own(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bif.own) break;
    end
    total++;
    if (bif.own !== 1'b1) begin
      bad++;
      $display("FAIL %s: own=%b required 1 within 40 clocks", name, bif.own);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bif.dma_req = 1'b1; bif.cycle_end = 1'b0; bif.cycle_busy = 1'b0; bif.dma_done = 1'b0;
    bif.bus_as_n = 1'b1; bif.bus_bgack_n = 1'b1; bif.berr_n = 1'b1; bif.err_clr = 1'b0;
    bg_man = 1'b1; bg_auto = 1'b1;
    repeat (3) @(negedge clk);
    total += 6;
    if (bif.br_n !== 1'b1)     begin bad++; $display("FAIL rst_br_n: got %b required 1", bif.br_n); end
    if (bif.bgack_n !== 1'b1)  begin bad++; $display("FAIL rst_bgack_n: got %b required 1", bif.bgack_n); end
    if (bif.bgack_oe !== 1'b0) begin bad++; $display("FAIL rst_bgack_oe: got %b required 0", bif.bgack_oe); end
    if (bif.own !== 1'b0)      begin bad++; $display("FAIL rst_own: got %b required 0", bif.own); end
    if (bif.dma_go !== 1'b0)   begin bad++; $display("FAIL rst_dma_go: got %b required 0", bif.dma_go); end
    if (bif.bus_err !== 1'b0)  begin bad++; $display("FAIL rst_bus_err: got %b required 0", bif.bus_err); end
    $display("reset: outputs checked while held in reset");
  endtask

  task automatic test_acquire;
    rst_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      @(negedge clk);
      total += 2;
      if (bif.br_n !== (e == 5)) begin bad++; $display("FAIL acq_br_n clk%0d: got %b required %b", e, bif.br_n, e == 5); end
      if (bif.own !== (e == 5))  begin bad++; $display("FAIL acq_own clk%0d: got %b required %b", e, bif.own, e == 5); end
    end
    total += 3;
    if (bif.dma_go !== 1'b1)   begin bad++; $display("FAIL acq_dma_go: got %b required 1", bif.dma_go); end
    if (bif.bgack_oe !== 1'b1) begin bad++; $display("FAIL acq_bgack_oe: got %b required 1", bif.bgack_oe); end
    if (bif.bgack_n !== 1'b0)  begin bad++; $display("FAIL acq_bgack_n: got %b required 0", bif.bgack_n); end
    $display("acquire: own observed at clock 5");
  endtask

  task automatic test_burst;
    int pulses = 0;
    int expv;
    exp_q.push_back(8);
    while (bif.dma_go && pulses < 20) begin
      bif.cycle_busy = 1'b1;
      repeat (5) @(negedge clk);
      bif.cycle_end = 1'b1;
      @(negedge clk);
      bif.cycle_end = 1'b0; bif.cycle_busy = 1'b0;
      pulses++;
    end
    expv = exp_q.pop_front();
    total++;
    if (pulses !== expv) begin bad++; $display("FAIL burst_count: got %0d cycles required %0d", pulses, expv); end
    total++;
    if (bif.own !== 1'b1) begin bad++; $display("FAIL burst_own_after_last: got %b required 1", bif.own); end
    @(negedge clk);
    total += 3;
    if (bif.own !== 1'b0)      begin bad++; $display("FAIL burst_release_own: got %b required 0", bif.own); end
    if (bif.bgack_oe !== 1'b1) begin bad++; $display("FAIL burst_release_oe: got %b required 1", bif.bgack_oe); end
    if (bif.bgack_n !== 1'b1)  begin bad++; $display("FAIL burst_release_bgack: got %b required 1", bif.bgack_n); end
    @(negedge clk);
    total += 2;
    if (bif.bgack_oe !== 1'b0) begin bad++; $display("FAIL burst_hold_oe: got %b required 0", bif.bgack_oe); end
    if (bif.br_n !== 1'b1)     begin bad++; $display("FAIL burst_hold1_br: got %b required 1", bif.br_n); end
    @(negedge clk);
    total++;
    if (bif.br_n !== 1'b1) begin bad++; $display("FAIL burst_hold2_br: got %b required 1", bif.br_n); end
    @(negedge clk);
    total++;
    if (bif.br_n !== 1'b1) begin bad++; $display("FAIL burst_idle_br: got %b required 1", bif.br_n); end
    @(negedge clk);
    total++;
    if (bif.br_n !== 1'b0) begin bad++; $display("FAIL burst_rereq_br: got %b required 0", bif.br_n); end
    $display("burst: tenure of %0d cycles, re-request after hold-off", pulses);
  endtask

  task automatic test_done;
    int pulses = 0;
    int expv;
    wait_own("done_acquire");
    exp_q.push_back(3);
    while (bif.dma_go && pulses < 20) begin
      bif.cycle_busy = 1'b1;
      repeat (5) @(negedge clk);
      bif.cycle_end = 1'b1;
      if (pulses == 2) bif.dma_done = 1'b1;
      @(negedge clk);
      bif.cycle_end = 1'b0; bif.dma_done = 1'b0; bif.cycle_busy = 1'b0;
      pulses++;
    end
    total += 2;
    if (bif.own !== 1'b1)   begin bad++; $display("FAIL done_drain_own: got %b required 1", bif.own); end
    if (bif.dma_go !== 1'b0) begin bad++; $display("FAIL done_drain_go: got %b required 0", bif.dma_go); end
    @(negedge clk);
    total++;
    if (bif.own !== 1'b0) begin bad++; $display("FAIL done_release_own: got %b required 0", bif.own); end
    expv = exp_q.pop_front();
    total++;
    if (pulses !== expv) begin bad++; $display("FAIL done_count: got %0d cycles required %0d", pulses, expv); end
    $display("done: tenure of %0d cycles ended by dma_done", pulses);
  endtask

  task automatic test_as_busy;
    bit early = 1'b0;
    int lat = 0;
    int expv;
    do_reset(1'b0, 1'b0);
    bif.bus_as_n = 1'b0;
    bif.dma_req = 1'b1;
    @(negedge clk);
    total++;
    if (bif.br_n !== 1'b0) begin bad++; $display("FAIL as_br_n: got %b required 0", bif.br_n); end
    bg_man = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bif.own !== 1'b0) early = 1'b1;
    end
    total++;
    if (early) begin bad++; $display("FAIL as_own_early: own rose while bus as_n low, required 0"); end
    bif.bus_as_n = 1'b1;
    exp_q.push_back(3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (bif.own) break;
    end
    expv = exp_q.pop_front();
    total++;
    if (lat !== expv) begin bad++; $display("FAIL as_latency: got %0d clocks required %0d", lat, expv); end
    $display("as_busy: own %0d clocks after as_n released", lat);
  endtask

  task automatic test_berr;
    bit stray = 1'b0;
    bif.cycle_busy = 1'b1;
    @(negedge clk);
    bif.berr_n = 1'b0;
    @(negedge clk);
    bif.berr_n = 1'b1;
    total++;
    if (bif.own !== 1'b1) begin bad++; $display("FAIL berr_own_e1: got %b required 1", bif.own); end
    @(negedge clk);
    bif.err_clr = 1'b1;
    total++;
    if (bif.own !== 1'b1) begin bad++; $display("FAIL berr_own_e2: got %b required 1", bif.own); end
    @(negedge clk);
    bif.err_clr = 1'b0;
    total += 3;
    if (bif.own !== 1'b0)     begin bad++; $display("FAIL berr_own_e3: got %b required 0", bif.own); end
    if (bif.bus_err !== 1'b1) begin bad++; $display("FAIL berr_flag_set_wins: got %b required 1", bif.bus_err); end
    if (bif.dma_go !== 1'b0)  begin bad++; $display("FAIL berr_dma_go: got %b required 0", bif.dma_go); end
    bif.cycle_busy = 1'b0;
    bg_man = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bif.br_n !== 1'b1) stray = 1'b1;
    end
    total++;
    if (stray) begin bad++; $display("FAIL berr_blocks_req: br_n asserted while bus_err set, required 1"); end
    bif.err_clr = 1'b1;
    @(negedge clk);
    bif.err_clr = 1'b0;
    total += 2;
    if (bif.bus_err !== 1'b0) begin bad++; $display("FAIL berr_clear: got %b required 0", bif.bus_err); end
    if (bif.br_n !== 1'b1)    begin bad++; $display("FAIL berr_clear_br: got %b required 1", bif.br_n); end
    @(negedge clk);
    total++;
    if (bif.br_n !== 1'b0) begin bad++; $display("FAIL berr_new_req: got %b required 0", bif.br_n); end
    bg_man = 1'b0;
    wait_own("berr_reacquire");
    $display("berr: error flagged, request blocked until clear, bus reacquired");
  endtask

  task automatic test_withdraw;
    bit oe_seen = 1'b0;
    do_reset(1'b0, 1'b0);
    bif.dma_req = 1'b1;
    @(negedge clk);
    total++;
    if (bif.br_n !== 1'b0) begin bad++; $display("FAIL wd_br_n: got %b required 0", bif.br_n); end
    bif.bus_bgack_n = 1'b0; bg_man = 1'b0;
    repeat (3) @(negedge clk);
    bg_man = 1'b1; bif.bus_bgack_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bif.bgack_oe !== 1'b0) oe_seen = 1'b1;
    end
    total++;
    if (bif.br_n !== 1'b0) begin bad++; $display("FAIL wd_grant_withdrawn_br: got %b required 0", bif.br_n); end
    bif.dma_req = 1'b0;
    @(negedge clk);
    total++;
    if (bif.br_n !== 1'b1) begin bad++; $display("FAIL wd_drop_br: got %b required 1", bif.br_n); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bif.bgack_oe !== 1'b0 || bif.br_n !== 1'b1) oe_seen = 1'b1;
    end
    total++;
    if (oe_seen) begin bad++; $display("FAIL wd_bgack_oe: bgack_oe rose or br_n reasserted, required quiet bus"); end
    $display("withdraw: request dropped before grant, bus untouched");
  endtask

  task automatic test_async_reset;
    int lat = 0;
    int expv;
    do_reset(1'b1, 1'b1);
    wait_own("arst_acquire");
    #2 rst_n = 1'b0;
    #1;
    total += 4;
    if (bif.own !== 1'b0)      begin bad++; $display("FAIL arst_own: got %b required 0", bif.own); end
    if (bif.dma_go !== 1'b0)   begin bad++; $display("FAIL arst_dma_go: got %b required 0", bif.dma_go); end
    if (bif.bgack_oe !== 1'b0) begin bad++; $display("FAIL arst_bgack_oe: got %b required 0", bif.bgack_oe); end
    if (bif.br_n !== 1'b1)     begin bad++; $display("FAIL arst_br_n: got %b required 1", bif.br_n); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(5);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (bif.own) break;
    end
    expv = exp_q.pop_front();
    total++;
    if (lat !== expv) begin bad++; $display("FAIL arst_reacquire_latency: got %0d clocks required %0d", lat, expv); end
    $display("async_reset: bus released mid-tenure, reacquired after %0d clocks", lat);
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_burst();
    test_done();
    test_as_busy();
    test_berr();
    test_withdraw();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
